uart_rx_param: RTL and testbench

//   Parametrised UART receiver, successor to the fixed 8N1 receiver. Synchronises the async serial

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_bit_sampler.sv | 67 ++++++
 rtl/uart_rx_param.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART receiver and the planned
// parametrised transmitter.
//   rx_state_e   - receiver FSM states
//   parity_e     - parity mode encoding (matches the PARITY parameter values)
//   clks_per_bit - system clocks per serial bit for a given clock and line rate
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler: synchronises the RX line, runs the per-bit counter and
// produces a 2-of-3 majority vote around mid-bit.
//   clk, rst    - system clock, synchronous active-high reset
//   i_serial    - asynchronous RX line (idle high)
//   i_run       - counter runs while high; held at 0 while low
//   o_line      - synchronised RX line
//   o_vote      - majority of the samples at counts H-1, H, H+1
//   o_get_bit   - strobe in the decision cycle (count H+1)
//   o_bit_end   - last count of the bit period
module uart_bit_sampler #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_serial,
  input  logic i_run,
  output logic o_line,
  output logic o_vote,
  output logic o_get_bit,
  output logic o_bit_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SMP_0    = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] SMP_1    = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] SMP_2    = CNT_W'(CLKS_PER_BIT / 2 + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_s0;
  logic                   r_s1;
  logic                   w_line;

  assign w_line = r_sync[SYNC_STAGES-1];

  // Synchroniser resets to 1 so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_serial};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_s0  <= 1'b0;
      r_s1  <= 1'b0;
    end else if (!i_run) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      if (r_cnt == SMP_0) r_s0 <= w_line;
      if (r_cnt == SMP_1) r_s1 <= w_line;
    end
  end

  // Third sample is the live synchronised line in the decision cycle.
  assign o_vote    = (r_s0 & r_s1) | (r_s0 & w_line) | (r_s1 & w_line);
  assign o_get_bit = i_run && (r_cnt == SMP_2);
  assign o_bit_end = i_run && (r_cnt == CNT_LAST);
  assign o_line    = w_line;

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (5-9 data bits, none/odd/even
// parity, 1 or 2 stop bits) with a one-entry valid/ready output register.
//   clk, rst       - system clock, synchronous active-high reset
//   serial_dat_in  - asynchronous RX line, idle high
//   rx_data        - received word, right-justified
//   rx_valid       - rx_data and flags hold a frame
//   rx_ready       - consumer accepts when rx_valid && rx_ready
//   frame_err      - a stop bit was sampled low
//   parity_err     - parity mismatch (always 0 with no parity)
//   overrun        - 1-cycle pulse when a finished frame is dropped
//   get_bit        - strobe at each mid-bit decision
//   busy           - receiver is inside a frame
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_dat_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 get_bit,
  output logic                 busy
);

  localparam int         CPB       = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam parity_e    PAR_MODE  = parity_e'(PARITY);
  localparam logic [3:0] IDX_DB    = 4'(DATA_BITS);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (CPB < 4) begin : g_bad_cpb
    $error("uart_rx_param: CLKS_PER_BIT must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("uart_rx_param: SYNC_STAGES must be at least 2");
  end

  rx_state_e            r_state;
  logic                 r_busy;
  logic [3:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_frm_err;
  logic                 r_par_err;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frm_out;
  logic                 r_par_out;
  logic                 r_overrun;

  logic       w_line;
  logic       w_vote;
  logic       w_get_bit;
  logic       w_bit_end;
  logic [3:0] w_idx_nxt;
  logic       w_par_exp;

  uart_bit_sampler #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .i_serial (serial_dat_in),
    .i_run    (r_busy),
    .o_line   (w_line),
    .o_vote   (w_vote),
    .o_get_bit(w_get_bit),
    .o_bit_end(w_bit_end)
  );

  // With the minimum bit length the vote and the bit end share a cycle, so
  // the data-complete test looks at the index including this cycle's vote.
  assign w_idx_nxt = r_idx + {3'b000, w_get_bit};

  // Expected parity bit: odd mode wants an odd total count of 1s.
  assign w_par_exp = (PAR_MODE == PAR_ODD) ? ~(^r_shift) : (^r_shift);

  // The PARITY state is written with its package scope because the local
  // PARITY parameter hides the imported enum literal.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_frm_err <= 1'b0;
      r_par_err <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_frm_out <= 1'b0;
      r_par_out <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_valid && rx_ready) r_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (!w_line) begin
            r_state   <= START;
            r_busy    <= 1'b1;
            r_idx     <= '0;
            r_frm_err <= 1'b0;
            r_par_err <= 1'b0;
          end
        end
        START: begin
          if (w_get_bit && w_vote) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_bit_end) begin
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_get_bit) begin
            r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
            r_idx   <= w_idx_nxt;
          end
          if (w_bit_end && (w_idx_nxt == IDX_DB)) begin
            r_idx   <= '0;
            r_state <= (PAR_MODE == PAR_NONE) ? STOP : uart_pkg::PARITY;
          end
        end
        uart_pkg::PARITY: begin
          if (w_get_bit) r_par_err <= (w_vote != w_par_exp);
          if (w_bit_end) r_state <= STOP;
        end
        STOP: begin
          if (w_get_bit) begin
            if (!w_vote) r_frm_err <= 1'b1;
            if (r_idx == LAST_STOP) begin
              // Frame ends at the last stop vote so the next start edge
              // can be caught; the final stop vote is folded in directly.
              r_state <= IDLE;
              r_busy  <= 1'b0;
              if (!r_valid || rx_ready) begin
                r_data    <= r_shift;
                r_frm_out <= r_frm_err | ~w_vote;
                r_par_out <= r_par_err;
                r_valid   <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign frame_err  = r_frm_out;
  assign parity_err = r_par_out;
  assign overrun    = r_overrun;
  assign get_bit    = w_get_bit;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four instances (8N1, 8E1, 7N2 at 115200 baud and a
// fast 9O2 instance for randomised frames checked against a reference model).
module tb_uart_rx_param;

  localparam int CPB_A = 434;
  localparam int CPB_D = 16;

  typedef struct {
    logic [8:0] data;
    logic       frm;
    logic       par;
  } cap_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_frm;
    int         exp_gets;
  } vec_t;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst, rst_c;
  logic ser_a, ser_b, ser_c, ser_d;
  logic rdy_a, rdy_b, rdy_c, rdy_d;

  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic [8:0] data_d;
  logic val_a, val_b, val_c, val_d;
  logic frm_a, frm_b, frm_c, frm_d;
  logic par_a, par_b, par_c, par_d;
  logic ovr_a, ovr_b, ovr_c, ovr_d;
  logic gb_a, gb_b, gb_c, gb_d;
  logic busy_a, busy_b, busy_c, busy_d;

  int n_chk = 0;
  int n_fail = 0;
  int n_get_a = 0, n_get_b = 0, n_get_c = 0, n_get_d = 0;
  int n_ovr_a = 0, n_ovr_b = 0, n_ovr_c = 0, n_ovr_d = 0;
  cap_t q_a[$], q_b[$], q_c[$], q_d[$];

  uart_rx_param u_a (
    .clk(clk), .rst(rst), .serial_dat_in(ser_a), .rx_data(data_a), .rx_valid(val_a),
    .rx_ready(rdy_a), .frame_err(frm_a), .parity_err(par_a), .overrun(ovr_a),
    .get_bit(gb_a), .busy(busy_a));

  uart_rx_param #(.PARITY(2)) u_b (
    .clk(clk), .rst(rst), .serial_dat_in(ser_b), .rx_data(data_b), .rx_valid(val_b),
    .rx_ready(rdy_b), .frame_err(frm_b), .parity_err(par_b), .overrun(ovr_b),
    .get_bit(gb_b), .busy(busy_b));

  uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2)) u_c (
    .clk(clk), .rst(rst_c), .serial_dat_in(ser_c), .rx_data(data_c), .rx_valid(val_c),
    .rx_ready(rdy_c), .frame_err(frm_c), .parity_err(par_c), .overrun(ovr_c),
    .get_bit(gb_c), .busy(busy_c));

  uart_rx_param #(.CLK_FREQ_HZ(50_000_000), .BAUD(3_125_000), .DATA_BITS(9),
                  .PARITY(1), .STOP_BITS(2)) u_d (
    .clk(clk), .rst(rst), .serial_dat_in(ser_d), .rx_data(data_d), .rx_valid(val_d),
    .rx_ready(rdy_d), .frame_err(frm_d), .parity_err(par_d), .overrun(ovr_d),
    .get_bit(gb_d), .busy(busy_d));

  always @(negedge clk) begin
    if (val_a && rdy_a) q_a.push_back('{{1'b0, data_a}, frm_a, par_a});
    if (val_b && rdy_b) q_b.push_back('{{1'b0, data_b}, frm_b, par_b});
    if (val_c && rdy_c) q_c.push_back('{{2'b00, data_c}, frm_c, par_c});
    if (val_d && rdy_d) q_d.push_back('{data_d, frm_d, par_d});
    if (gb_a) n_get_a++;
    if (gb_b) n_get_b++;
    if (gb_c) n_get_c++;
    if (gb_d) n_get_d++;
    if (ovr_a) n_ovr_a++;
    if (ovr_b) n_ovr_b++;
    if (ovr_c) n_ovr_c++;
    if (ovr_d) n_ovr_d++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic set_line(input int inst, input logic v);
    case (inst)
      0: ser_a = v;
      1: ser_b = v;
      2: ser_c = v;
      default: ser_d = v;
    endcase
  endtask

  task automatic idle(input int inst, input int nbit, input int cpb);
    set_line(inst, 1'b1);
    repeat (nbit * cpb) @(negedge clk);
  endtask

  // stops[0] is the first stop bit on the line.
  task automatic send_frame(input int inst, input logic [8:0] data, input int nbits,
                            input bit has_par, input logic pbit, input int nstop,
                            input logic [1:0] stops, input int cpb);
    logic q[$];
    q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) q.push_back(data[i]);
    if (has_par) q.push_back(pbit);
    for (int s = 0; s < nstop; s++) q.push_back(stops[s]);
    foreach (q[k]) begin
      set_line(inst, q[k]);
      repeat (cpb) @(negedge clk);
    end
    set_line(inst, 1'b1);
  endtask

  task automatic pop_chk(input string nm, inout cap_t q[$], input int exp_data,
                         input int exp_frm, input int exp_par);
    cap_t c;
    chk({nm, "_nvalid"}, q.size(), 1);
    if (q.size() > 0) begin
      c = q.pop_front();
      chk({nm, "_data"}, int'(c.data), exp_data);
      chk({nm, "_frame_err"}, int'(c.frm), exp_frm);
      chk({nm, "_parity_err"}, int'(c.par), exp_par);
    end
  endtask

  vec_t tab[3];
  int   g0, o0, exp_get_d;
  logic [8:0] rd;
  logic       pbit;
  logic [1:0] stops;
  int   ones, e_par, e_frm;

  initial begin
    tab[0] = '{8'h61, 1'b1, 8'h61, 1'b0, 10};
    tab[1] = '{8'h55, 1'b0, 8'h55, 1'b1, 10};
    tab[2] = '{8'hA3, 1'b1, 8'hA3, 1'b0, 10};

    ser_a = 1'b1; ser_b = 1'b1; ser_c = 1'b1; ser_d = 1'b1;
    rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1; rdy_d = 1'b1;
    rst = 1'b1; rst_c = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_outs_a", int'({val_a, data_a, frm_a, par_a, ovr_a, gb_a, busy_a}), 0);
    chk("rst_outs_d", int'({val_d, data_d, frm_d, par_d, ovr_d, gb_d, busy_d}), 0);
    rst = 1'b0; rst_c = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_outs_a", int'({val_a, data_a, frm_a, par_a, ovr_a, gb_a, busy_a}), 0);

    // 8N1 table: clean frame, stop bit low, clean frame after the error.
    for (int i = 0; i < 3; i++) begin
      g0 = n_get_a;
      send_frame(0, {1'b0, tab[i].data}, 8, 1'b0, 1'b0, 1, {1'b1, tab[i].stop}, CPB_A);
      chk("a_get_bits", n_get_a - g0, tab[i].exp_gets);
      pop_chk("a_tab", q_a, int'(tab[i].exp_data), int'(tab[i].exp_frm), 0);
      idle(0, 2, CPB_A);
      chk("a_no_spurious", q_a.size(), 0);
      chk("a_busy_after", int'(busy_a), 0);
    end

    // 2 us low glitch: one start vote, then back to idle with nothing delivered.
    g0 = n_get_a;
    set_line(0, 1'b0);
    repeat (50) @(negedge clk);
    chk("glitch_busy_seen", int'(busy_a), 1);
    repeat (50) @(negedge clk);
    idle(0, 2, CPB_A);
    chk("glitch_get_bits", n_get_a - g0, 1);
    chk("glitch_no_valid", q_a.size(), 0);
    chk("glitch_idle", int'(busy_a), 0);

    // Output full: second frame is dropped with one overrun pulse.
    @(posedge clk); #1 rdy_a = 1'b0;
    o0 = n_ovr_a;
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 2'b11, CPB_A);
    idle(0, 1, CPB_A);
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 2'b11, CPB_A);
    idle(0, 1, CPB_A);
    chk("ovr_valid_held", int'(val_a), 1);
    chk("ovr_data_held", int'(data_a), 'h11);
    chk("ovr_pulses", n_ovr_a - o0, 1);
    @(posedge clk); #1 rdy_a = 1'b1;
    repeat (3) @(negedge clk);
    pop_chk("ovr_accept", q_a, 'h11, 0, 0);
    chk("ovr_valid_clear", int'(val_a), 0);

    // Even parity: 0x61 has three 1s, so parity bit 1 is correct and 0 is an error.
    g0 = n_get_b;
    send_frame(1, 9'h061, 8, 1'b1, 1'b1, 1, 2'b11, CPB_A);
    chk("b_get_bits", n_get_b - g0, 11);
    pop_chk("b_par_ok", q_b, 'h61, 0, 0);
    idle(1, 2, CPB_A);
    send_frame(1, 9'h061, 8, 1'b1, 1'b0, 1, 2'b11, CPB_A);
    pop_chk("b_par_bad", q_b, 'h61, 0, 1);
    idle(1, 2, CPB_A);
    chk("b_busy_after", int'(busy_b), 0);

    // 7 data bits, 2 stop bits.
    g0 = n_get_c;
    send_frame(2, 9'h07F, 7, 1'b0, 1'b0, 2, 2'b11, CPB_A);
    chk("c_get_bits", n_get_c - g0, 10);
    pop_chk("c_7f", q_c, 'h7F, 0, 0);
    idle(2, 2, CPB_A);
    send_frame(2, 9'h015, 7, 1'b0, 1'b0, 2, 2'b01, CPB_A);
    pop_chk("c_second_stop_low", q_c, 'h15, 1, 0);
    idle(2, 2, CPB_A);

    // Reset in the middle of the data bits: frame abandoned, nothing delivered.
    fork
      send_frame(2, 9'h07F, 7, 1'b0, 1'b0, 2, 2'b11, CPB_A);
      begin
        repeat (3 * CPB_A) @(negedge clk);
        chk("c_busy_mid", int'(busy_c), 1);
        rst_c = 1'b1;
        repeat (4) @(negedge clk);
        chk("c_rst_outs", int'({val_c, data_c, frm_c, par_c, ovr_c, gb_c, busy_c}), 0);
        rst_c = 1'b0;
      end
    join
    idle(2, 2, CPB_A);
    chk("c_rst_no_valid", q_c.size(), 0);
    chk("c_rst_idle", int'(busy_c), 0);

    // Randomised 9O2 frames against a count-of-ones model.
    exp_get_d = n_get_d;
    for (int f = 0; f < 30; f++) begin
      rd = 9'($urandom_range(0, 511));
      pbit = ~(^rd);
      if ($urandom_range(0, 3) == 0) pbit = ~pbit;
      stops[0] = ($urandom_range(0, 4) != 0);
      stops[1] = ($urandom_range(0, 4) != 0);
      ones  = $countones(rd) + int'(pbit);
      e_par = (ones % 2 == 0) ? 1 : 0;
      e_frm = (stops != 2'b11) ? 1 : 0;
      send_frame(3, rd, 9, 1'b1, pbit, 2, stops, CPB_D);
      pop_chk("d_rand", q_d, int'(rd), e_frm, e_par);
      // Start, 9 data, parity, 2 stops; a low last stop bit is seen as a
      // start edge afterwards and rejected with one more vote.
      exp_get_d += 13 + ((stops[1] == 1'b0) ? 1 : 0);
      idle(3, (stops[1] == 1'b0) ? 3 : $urandom_range(0, 2), CPB_D);
    end
    idle(3, 2, CPB_D);
    chk("d_get_bits_total", n_get_d, exp_get_d);
    chk("d_no_spurious", q_d.size(), 0);
    chk("d_busy_end", int'(busy_d), 0);
    chk("no_overrun_bcd", n_ovr_b + n_ovr_c + n_ovr_d, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
